// File: rtl/icache_pkg.sv
// Shared geometry, state encoding and region helper for the direct-mapped
// instruction cache.
package icache_pkg;

   localparam int ICACHE_IDX_W = 6;
   localparam int ICACHE_TAG_W = 32 - 2 - ICACHE_IDX_W;
   localparam int ICACHE_LINES = 1 << ICACHE_IDX_W;

   typedef enum logic [1:0] {
      IC_IDLE   = 2'd0,
      IC_REFILL = 2'd1,
      IC_RESP   = 2'd2
   } ic_state_t;

   // The IO window is never cached; callers pass address bits [17:16].
   function automatic logic is_io(input logic [1:0] region);
      return region == 2'b11;
   endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the instruction cache: combinational read,
// single synchronous write port, valid bits cleared by reset.
module icache_array
   import icache_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ICACHE_IDX_W-1:0] rd_idx,
   output logic                    rd_valid,
   output logic [ICACHE_TAG_W-1:0] rd_tag,
   output logic [31:0]             rd_data,
   input  logic                    wr_en,
   input  logic [ICACHE_IDX_W-1:0] wr_idx,
   input  logic [ICACHE_TAG_W-1:0] wr_tag,
   input  logic [31:0]             wr_data
);

   logic [ICACHE_LINES-1:0] valid;
   logic [ICACHE_TAG_W-1:0] tag_mem  [ICACHE_LINES];
   logic [31:0]             data_mem [ICACHE_LINES];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_idx] <= 1'b1;
      end
   end

   // Tag and data need no reset: a line is only trusted once its valid bit is set.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wr_idx]  <= wr_tag;
         data_mem[wr_idx] <= wr_data;
      end
   end

   assign rd_valid = valid[rd_idx];
   assign rd_tag   = tag_mem[rd_idx];
   assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache controller: one-cycle hits, single-word
// refill through the memory controller fetch handshake, flush abort.
module icache
   import icache_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        flush,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_flg,
   output logic [31:0] if_inst,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_flg,
   input  logic [31:0] mem_inst,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
);

   ic_state_t state;
   logic      flg_q;

   logic                    rd_valid;
   logic [ICACHE_TAG_W-1:0] rd_tag;
   logic [31:0]             rd_data;
   logic                    hit;
   logic                    wr_en;
   logic [31:0]             word_addr;

   assign word_addr = if_addr & 32'hFFFF_FFFC;

   icache_array u_array (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (if_addr[ICACHE_IDX_W+1:2]),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .wr_en    (wr_en),
      .wr_idx   (mem_addr[ICACHE_IDX_W+1:2]),
      .wr_tag   (mem_addr[31:ICACHE_IDX_W+2]),
      .wr_data  (mem_inst)
   );

   assign hit = rd_valid && (rd_tag == if_addr[31:ICACHE_IDX_W+2])
                && !is_io(if_addr[17:16]);

   // A flush landing together with mem_flg must not fill the line.
   assign wr_en = rdy && !flush && (state == IC_REFILL) && mem_flg
                  && !is_io(mem_addr[17:16]);

   assign if_flg = flg_q && !(flush && rdy);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IC_IDLE;
         flg_q    <= 1'b0;
         if_inst  <= '0;
         mem_req  <= 1'b0;
         mem_addr <= '0;
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (rdy) begin
         if (flush) begin
            state   <= IC_IDLE;
            flg_q   <= 1'b0;
            mem_req <= 1'b0;
         end else begin
            case (state)
               IC_IDLE: begin
                  if (if_req) begin
                     if (hit) begin
                        if_inst <= rd_data;
                        hit_cnt <= hit_cnt + 32'd1;
                        flg_q   <= 1'b1;
                        state   <= IC_RESP;
                     end else begin
                        mem_addr <= word_addr;
                        mem_req  <= 1'b1;
                        miss_cnt <= miss_cnt + 32'd1;
                        state    <= IC_REFILL;
                     end
                  end
               end
               IC_REFILL: begin
                  if (mem_flg) begin
                     if_inst <= mem_inst;
                     mem_req <= 1'b0;
                     flg_q   <= 1'b1;
                     state   <= IC_RESP;
                  end
               end
               IC_RESP: begin
                  flg_q <= 1'b0;
                  state <= IC_IDLE;
               end
               default: begin
                  flg_q   <= 1'b0;
                  mem_req <= 1'b0;
                  state   <= IC_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed vector table, flush/stall/reset
// sequences, then random fetches checked against a line-map reference model.
module tb_icache;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        flush;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_flg;
   logic [31:0] if_inst;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_flg;
   logic [31:0] mem_inst;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;

   int total = 0;
   int bad   = 0;

   // Reference model: which word address each of the 64 lines holds.
   bit          m_valid [64];
   logic [29:0] m_line  [64];
   logic [31:0] m_data  [64];
   int          m_hits;
   int          m_misses;

   typedef struct {
      logic [31:0] addr;
      int          delay;
      logic [31:0] data;
      bit          exp_hit;
      logic [31:0] exp_inst;
   } vec_t;

   vec_t vecs [6];

   always #5 clk = ~clk;

   icache dut (
      .clk      (clk),
      .rst      (rst),
      .rdy      (rdy),
      .flush    (flush),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_flg   (if_flg),
      .if_inst  (if_inst),
      .mem_req  (mem_req),
      .mem_addr (mem_addr),
      .mem_flg  (mem_flg),
      .mem_inst (mem_inst),
      .hit_cnt  (hit_cnt),
      .miss_cnt (miss_cnt)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
                  name, actual, expected, $time);
      end
   endtask

   task automatic modelClear();
      for (int i = 0; i < 64; i++) m_valid[i] = 0;
      m_hits   = 0;
      m_misses = 0;
   endtask

   function automatic bit addrIsIo(input logic [31:0] a);
      logic [31:0] t;
      t = a >> 16;
      return (t % 4) == 3;
   endfunction

   function automatic bit modelHit(input logic [31:0] a);
      int idx;
      idx = (a >> 2) % 64;
      return !addrIsIo(a) && m_valid[idx] && (m_line[idx] == a[31:2]);
   endfunction

   function automatic logic [31:0] modelData(input logic [31:0] a);
      return m_data[(a >> 2) % 64];
   endfunction

   task automatic modelUpdate(input logic [31:0] a, input bit was_hit,
                              input logic [31:0] d);
      int idx;
      idx = (a >> 2) % 64;
      if (was_hit) begin
         m_hits++;
      end else begin
         m_misses++;
         if (!addrIsIo(a)) begin
            m_valid[idx] = 1;
            m_line[idx]  = a[31:2];
            m_data[idx]  = d;
         end
      end
   endtask

   task automatic checkCounters(input string tag);
      checkOutput({tag, "_hit_cnt"}, hit_cnt, 32'(m_hits));
      checkOutput({tag, "_miss_cnt"}, miss_cnt, 32'(m_misses));
   endtask

   task automatic doReset();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      modelClear();
   endtask

   // One complete fetch; called #1 after a rising edge with the DUT in IDLE.
   task automatic applyStimulus(input logic [31:0] addr, input int delay,
                                input logic [31:0] data, input bit exp_hit,
                                input logic [31:0] exp_inst);
      if_req  = 1'b1;
      if_addr = addr;
      @(posedge clk); #1;
      if (exp_hit) begin
         checkOutput("hit_flg", 32'(if_flg), 32'd1);
         checkOutput("hit_inst", if_inst, exp_inst);
         checkOutput("hit_mem_req", 32'(mem_req), 32'd0);
      end else begin
         checkOutput("miss_mem_req", 32'(mem_req), 32'd1);
         checkOutput("miss_mem_addr", mem_addr, {addr[31:2], 2'b00});
         checkOutput("miss_flg", 32'(if_flg), 32'd0);
         for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1;
            checkOutput("refill_hold_req", 32'(mem_req), 32'd1);
            checkOutput("refill_hold_addr", mem_addr, {addr[31:2], 2'b00});
         end
         mem_flg  = 1'b1;
         mem_inst = data;
         @(posedge clk); #1;
         mem_flg  = 1'b0;
         mem_inst = 32'h0;
         checkOutput("refill_flg", 32'(if_flg), 32'd1);
         checkOutput("refill_inst", if_inst, data);
         checkOutput("refill_req_drop", 32'(mem_req), 32'd0);
      end
      if_req = 1'b0;
      modelUpdate(addr, exp_hit, data);
      @(posedge clk); #1;
      checkOutput("idle_flg", 32'(if_flg), 32'd0);
      checkOutput("idle_mem_req", 32'(mem_req), 32'd0);
      checkCounters("post");
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] d;
      bit          h;

      rst      = 1'b1;
      rdy      = 1'b1;
      flush    = 1'b0;
      if_req   = 1'b0;
      if_addr  = 32'h0;
      mem_flg  = 1'b0;
      mem_inst = 32'h0;

      vecs[0] = '{32'h0000_0004, 4, 32'h0000_0013, 1'b0, 32'h0};
      vecs[1] = '{32'h0000_0004, 0, 32'h0,         1'b1, 32'h0000_0013};
      vecs[2] = '{32'h0000_0104, 1, 32'h00A0_0093, 1'b0, 32'h0};
      vecs[3] = '{32'h0000_0004, 2, 32'h0000_0013, 1'b0, 32'h0};
      vecs[4] = '{32'h0003_0000, 1, 32'hDEAD_BEEF, 1'b0, 32'h0};
      vecs[5] = '{32'h0003_0000, 0, 32'hDEAD_BEEF, 1'b0, 32'h0};

      doReset();
      checkOutput("rst_if_flg", 32'(if_flg), 32'd0);
      checkOutput("rst_if_inst", if_inst, 32'd0);
      checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
      checkOutput("rst_mem_addr", mem_addr, 32'd0);
      checkOutput("rst_hit_cnt", hit_cnt, 32'd0);
      checkOutput("rst_miss_cnt", miss_cnt, 32'd0);

      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].addr, vecs[i].delay, vecs[i].data,
                       vecs[i].exp_hit, vecs[i].exp_inst);
         if (i == 3) checkOutput("conflict_miss_cnt", miss_cnt, 32'd3);
      end
      checkOutput("io_hit_cnt", hit_cnt, 32'd1);
      checkOutput("io_miss_cnt", miss_cnt, 32'd5);

      // Flush on the second refill cycle, coincident with mem_flg.
      if_req  = 1'b1;
      if_addr = 32'h0000_0200;
      @(posedge clk); #1;
      checkOutput("flush_first_req", 32'(mem_req), 32'd1);
      m_misses++;
      @(posedge clk); #1;
      flush    = 1'b1;
      mem_flg  = 1'b1;
      mem_inst = 32'h1111_2222;
      if_req   = 1'b0;
      #1;
      checkOutput("flush_flg_gate", 32'(if_flg), 32'd0);
      @(posedge clk); #1;
      flush    = 1'b0;
      mem_flg  = 1'b0;
      checkOutput("flush_mem_req", 32'(mem_req), 32'd0);
      checkOutput("flush_no_flg", 32'(if_flg), 32'd0);
      @(posedge clk); #1;
      checkOutput("flush_still_no_flg", 32'(if_flg), 32'd0);
      checkCounters("flush");
      applyStimulus(32'h0000_0200, 1, 32'h3333_4444, 1'b0, 32'h0);

      // Stall in RESP: rdy low for three edges.
      if_req  = 1'b1;
      if_addr = 32'h0000_0004;
      @(posedge clk); #1;
      if_req = 1'b0;
      rdy    = 1'b0;
      m_hits++;
      checkOutput("stall_resp_flg", 32'(if_flg), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checkOutput("stall_hold_flg", 32'(if_flg), 32'd1);
         checkOutput("stall_hold_inst", if_inst, 32'h0000_0013);
         checkCounters("stall");
      end
      rdy = 1'b1;
      @(posedge clk); #1;
      checkOutput("stall_release_flg", 32'(if_flg), 32'd0);
      checkOutput("stall_release_req", 32'(mem_req), 32'd0);

      // Flush during RESP masks if_flg combinationally.
      if_req  = 1'b1;
      if_addr = 32'h0000_0004;
      @(posedge clk); #1;
      if_req = 1'b0;
      m_hits++;
      checkOutput("resp_flg_before_flush", 32'(if_flg), 32'd1);
      flush = 1'b1;
      #1;
      checkOutput("resp_flg_gated", 32'(if_flg), 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      checkOutput("resp_flush_idle", 32'(if_flg), 32'd0);
      checkCounters("resp_flush");

      // Asynchronous reset mid-refill clears outputs and all valid bits.
      if_req  = 1'b1;
      if_addr = 32'h0000_0010;
      @(posedge clk); #1;
      checkOutput("arst_pre_req", 32'(mem_req), 32'd1);
      rst    = 1'b1;
      if_req = 1'b0;
      #1;
      checkOutput("arst_mem_req", 32'(mem_req), 32'd0);
      checkOutput("arst_mem_addr", mem_addr, 32'd0);
      checkOutput("arst_miss_cnt", miss_cnt, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      modelClear();
      applyStimulus(32'h0000_0004, 0, 32'h0000_0055, 1'b0, 32'h0);

      // Random fetches over a small address pool so hits and conflicts occur.
      for (int n = 0; n < 300; n++) begin
         a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
             | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) a = a | 32'h0003_0000;
         d = $urandom;
         h = modelHit(a);
         applyStimulus(a, $urandom_range(0, 3), d, h, h ? modelData(a) : 32'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
